spi_reg_burst: RTL and testbench
================================

Name: spi_reg_burst

Overview:
Parametrised SPI register-bus slave, successor to the single-byte SPI register port in the test harness. Supports configurable register width and SPI mode, and multi-word burst read/write with address auto-increment within one chip-select frame. Sits between the external SPI pins, already on the `clk` domain, and the harness register file. All SPI inputs are oversampled; `clk` must be at least 8x `spi_clk`.

Parameters:
- ADDR_W, 7, register address width; legal range 1..7.
- REG_W, 8, register data width in bits; must be a multiple of 8, range 8..32.
- CPOL, 0, SPI clock idle level.
- CPHA, 0, SPI clock phase. 0 = sample on leading edge; 1 = sample on trailing edge.

Ports:
- clk  in  1  system clock
- rstb  in  1  reset; synchronous, active-low
- ena  in  1  clock enable; when low, all state holds
- spi_clk  in  1  SPI clock (asynchronous)
- spi_cs_n  in  1  SPI chip select, active-low (asynchronous)
- spi_mosi  in  1  SPI data in (asynchronous)
- spi_miso  out  1  SPI data out
- reg_addr  out  ADDR_W  current register address
- reg_data_i  in  REG_W  read data from register file
- reg_rd  out  1  one-clk read strobe
- reg_data_o  out  REG_W  write data
- reg_data_o_dv  out  1  one-clk write strobe
- busy  out  1  high while a frame is active (state != IDLE)

Behaviour:
- Input synchronisation: 2-flop synchroniser on spi_clk, spi_cs_n and spi_mosi, followed by edge detectors. Edges count only while synced cs_n is low.
- Edge mapping:
  - leading edge = rising if CPOL=0, falling if CPOL=1.
  - sample edge = leading edge if CPHA=0, trailing edge if CPHA=1.
  - shift edge = the other edge.
- Frame layout, MSB first:
  - command byte {rw, 7 addr bits}; address = low ADDR_W bits. rw=1 is write, rw=0 is read.
  - then N data words of REG_W bits each, N >= 0.
- FSM states: IDLE, CMD, WR_DATA, RD_LOAD, RD_DATA.
  - IDLE -> CMD on cs_n falling edge. Bit counter cleared.
  - CMD: shift in 8 bits on sample edges. On the 8th bit, latch reg_addr and rw, then go to WR_DATA (rw=1) or RD_LOAD (rw=0).
  - WR_DATA: shift in REG_W bits. On the last bit, reg_data_o = shift buffer and reg_data_o_dv pulses for 1 clk with reg_addr stable. The clk after the pulse, reg_addr increments and the next word begins.
  - RD_LOAD: reg_rd pulses 1 clk. reg_data_i is captured into the shift buffer on the following clk, then -> RD_DATA.
  - RD_DATA:
    - CPHA=0: MISO shows the buffer MSB immediately; the buffer shifts left on shift edges.
    - CPHA=1: the buffer shifts on leading edges; the first leading edge presents the MSB.
    - After REG_W sample edges, reg_addr increments and state -> RD_LOAD for the next word.
- Address increment wraps modulo 2^ADDR_W (e.g. 0x7F -> 0x00 for ADDR_W=7).
- spi_miso = shift buffer MSB in RD_DATA, else 0.
- cs_n rising in any state -> IDLE on the next clk.
  - A partial write word is discarded: no dv.
  - A partial command is discarded: reg_addr unchanged.
  - A read word in progress is simply dropped.
- If cs_n rises on the same clk as the last write bit, the dv still fires for that completed word.
- Reset (rstb low at a clk edge, regardless of ena): state IDLE, counters 0, reg_addr 0, reg_data_o 0, reg_data_o_dv 0, reg_rd 0, spi_miso 0, busy 0. Applies mid-frame too; the rest of the frame is ignored until the next cs_n falling edge.
- ena low: all registers hold, including synchronisers and edge history. No strobes fire.
- Strobes never overlap; at most one of reg_rd / reg_data_o_dv is high per clk.

Optional Feature:
Macro SPI_REG_BURST_AUTOINC_EN.
- Defined: reg_addr increments after each data word, as above.
- Undefined: reg_addr is held for the whole frame. Bursts repeatedly write or read the same address (FIFO-port style). Strobes still fire once per word.

Test Plan:
1. Mode 0, REG_W=8: write frame 0x85, 0xA5 -> one dv, reg_addr=0x05, reg_data_o=0xA5; busy falls after cs_n high.
2. Mode 0: read frame 0x03 with reg_data_i=0x3C at addr 3 -> one reg_rd; MISO bits 0,0,1,1,1,1,0,0.
3. Mode 3, REG_W=16: write burst 0xFE, 0x1234, 0xABCD -> dv at addr 0x7E with 0x1234, then dv at addr 0x7F with 0xABCD. With SPI_REG_BURST_AUTOINC_EN undefined, both dvs are at 0x7E.
4. Address wrap, ADDR_W=7: read burst from 0x7F, 2 words -> reg_rd at 0x7F then at 0x00.
5. Abort: cs_n rises after 5 bits of a write data word -> no dv; next frame 0x81, 0x55 -> dv at addr 1, data 0x55.
6. rstb low mid-burst, and ena held low for 20 clks mid-word -> all outputs reset / state frozen; frame continues correctly once ena returns.

Source files
------------

// File: rtl/spi_reg_burst.sv
// spi_reg_burst: oversampled SPI slave giving burst access to a register file.
// Define SPI_REG_BURST_AUTOINC_EN to advance reg_addr after every data word.
module spi_reg_burst #(
    parameter int ADDR_W = 7,
    parameter int REG_W  = 8,
    parameter bit CPOL   = 1'b0,
    parameter bit CPHA   = 1'b0
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [REG_W-1:0]  reg_data_i,
    output logic              reg_rd,
    output logic [REG_W-1:0]  reg_data_o,
    output logic              reg_data_o_dv,
    output logic              busy
);

`ifdef SPI_REG_BURST_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam int CNT_W = $clog2(REG_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(REG_W - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR_DATA,
        S_RD_LOAD,
        S_RD_DATA
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cs_pipe_q, cs_pipe_d;
    logic [2:0]        sck_pipe_q, sck_pipe_d;
    logic [1:0]        mosi_pipe_q, mosi_pipe_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REG_W-1:0]  shreg_q, shreg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REG_W-1:0]  data_o_q, data_o_d;
    logic              dv_q, dv_d;
    logic              rd_q, rd_d;
    logic              wr_inc_q, wr_inc_d;
    logic              lead_seen_q, lead_seen_d;
    logic              miso_q, miso_d;
    logic              busy_q, busy_d;

    logic             cs_fall, cs_rise, cs_act;
    logic             sck_rise, sck_fall;
    logic             lead, trail, sample, shift;
    logic             mosi_s;
    logic [REG_W-1:0] sh_in;
    logic [7:0]       cmd_byte;

    // Pipe index 0/1 are the synchroniser, index 2 is the edge history.
    assign cs_fall  = cs_pipe_q[2] & ~cs_pipe_q[1];
    assign cs_rise  = ~cs_pipe_q[2] & cs_pipe_q[1];
    assign cs_act   = ~cs_pipe_q[2];
    assign sck_rise = cs_act & ~sck_pipe_q[2] & sck_pipe_q[1];
    assign sck_fall = cs_act & sck_pipe_q[2] & ~sck_pipe_q[1];
    assign lead     = CPOL ? sck_fall : sck_rise;
    assign trail    = CPOL ? sck_rise : sck_fall;
    assign sample   = CPHA ? trail : lead;
    assign shift    = CPHA ? lead : trail;
    assign mosi_s   = mosi_pipe_q[1];
    assign sh_in    = {shreg_q[REG_W-2:0], mosi_s};
    assign cmd_byte = {shreg_q[6:0], mosi_s};

    always_comb begin
        cs_pipe_d   = {cs_pipe_q[1:0], spi_cs_n};
        sck_pipe_d  = {sck_pipe_q[1:0], spi_clk};
        mosi_pipe_d = {mosi_pipe_q[0], spi_mosi};
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        addr_d      = addr_q;
        data_o_d    = data_o_q;
        dv_d        = 1'b0;
        wr_inc_d    = 1'b0;
        lead_seen_d = lead_seen_q;

        if (wr_inc_q && AUTOINC) begin
            addr_d = addr_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                end
            end
            S_CMD: begin
                if (sample) begin
                    shreg_d = sh_in;
                    if (cnt_q == CMD_LAST) begin
                        cnt_d   = '0;
                        addr_d  = cmd_byte[ADDR_W-1:0];
                        state_d = cmd_byte[7] ? S_WR_DATA : S_RD_LOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WR_DATA: begin
                if (sample) begin
                    shreg_d = sh_in;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d    = '0;
                        data_o_d = sh_in;
                        dv_d     = 1'b1;
                        wr_inc_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RD_LOAD: begin
                shreg_d     = reg_data_i;
                cnt_d       = '0;
                lead_seen_d = 1'b0;
                state_d     = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (sample) begin
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = S_RD_LOAD;
                        if (AUTOINC) begin
                            addr_d = addr_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (shift) begin
                    // Ignore the shift edge trailing the previous word's last sample.
                    if (CPHA) begin
                        if (lead_seen_q) begin
                            shreg_d = shreg_q << 1;
                        end
                        lead_seen_d = 1'b1;
                    end else if (cnt_q != '0) begin
                        shreg_d = shreg_q << 1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cs_rise) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end

        rd_d   = (state_d == S_RD_LOAD);
        busy_d = (state_d != S_IDLE);
        miso_d = (state_d == S_RD_DATA) & shreg_d[REG_W-1];
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q     <= S_IDLE;
            cs_pipe_q   <= '0;
            sck_pipe_q  <= '0;
            mosi_pipe_q <= '0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            addr_q      <= '0;
            data_o_q    <= '0;
            dv_q        <= 1'b0;
            rd_q        <= 1'b0;
            wr_inc_q    <= 1'b0;
            lead_seen_q <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            cs_pipe_q   <= cs_pipe_d;
            sck_pipe_q  <= sck_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            addr_q      <= addr_d;
            data_o_q    <= data_o_d;
            dv_q        <= dv_d;
            rd_q        <= rd_d;
            wr_inc_q    <= wr_inc_d;
            lead_seen_q <= lead_seen_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
        end
    end

    assign spi_miso      = miso_q;
    assign reg_addr      = addr_q;
    assign reg_rd        = rd_q;
    assign reg_data_o    = data_o_q;
    assign reg_data_o_dv = dv_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_spi_reg_burst.sv
// tb_spi_reg_burst: directed bench for a mode-0/8-bit and a mode-3/16-bit
// instance, covering writes, reads, bursts, wrap, abort, reset and enable.
`timescale 1ns/1ps
module tb_spi_reg_burst;

`ifdef SPI_REG_BURST_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb, ena;

    logic        a_sck, a_cs_n, a_mosi, a_miso;
    logic [6:0]  a_addr;
    logic [7:0]  a_di, a_do;
    logic        a_rd, a_dv, a_busy;

    logic        b_sck, b_cs_n, b_mosi, b_miso;
    logic [6:0]  b_addr;
    logic [15:0] b_di, b_do;
    logic        b_rd, b_dv, b_busy;

    logic [7:0]  regs_a [128];
    logic [15:0] regs_b [128];
    assign a_di = regs_a[a_addr];
    assign b_di = regs_b[b_addr];

    spi_reg_burst #(.ADDR_W(7), .REG_W(8), .CPOL(1'b0), .CPHA(1'b0)) u_a (
        .clk(clk), .rstb(rstb), .ena(ena),
        .spi_clk(a_sck), .spi_cs_n(a_cs_n), .spi_mosi(a_mosi), .spi_miso(a_miso),
        .reg_addr(a_addr), .reg_data_i(a_di), .reg_rd(a_rd),
        .reg_data_o(a_do), .reg_data_o_dv(a_dv), .busy(a_busy)
    );

    spi_reg_burst #(.ADDR_W(7), .REG_W(16), .CPOL(1'b1), .CPHA(1'b1)) u_b (
        .clk(clk), .rstb(rstb), .ena(ena),
        .spi_clk(b_sck), .spi_cs_n(b_cs_n), .spi_mosi(b_mosi), .spi_miso(b_miso),
        .reg_addr(b_addr), .reg_data_i(b_di), .reg_rd(b_rd),
        .reg_data_o(b_do), .reg_data_o_dv(b_dv), .busy(b_busy)
    );

    int total = 0;
    int bad = 0;
    int ovl = 0;
    logic [6:0]  a_dv_addr [$];
    logic [7:0]  a_dv_data [$];
    logic [6:0]  a_rd_addr [$];
    logic [6:0]  b_dv_addr [$];
    logic [15:0] b_dv_data [$];
    logic [6:0]  b_rd_addr [$];

    always @(negedge clk) begin
        if (a_dv === 1'b1) begin
            a_dv_addr.push_back(a_addr);
            a_dv_data.push_back(a_do);
        end
        if (a_rd === 1'b1) a_rd_addr.push_back(a_addr);
        if (b_dv === 1'b1) begin
            b_dv_addr.push_back(b_addr);
            b_dv_data.push_back(b_do);
        end
        if (b_rd === 1'b1) b_rd_addr.push_back(b_addr);
        if ((a_dv === 1'b1 && a_rd === 1'b1) || (b_dv === 1'b1 && b_rd === 1'b1)) ovl++;
    end

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic clear_q();
        a_dv_addr.delete(); a_dv_data.delete(); a_rd_addr.delete();
        b_dv_addr.delete(); b_dv_data.delete(); b_rd_addr.delete();
    endtask

    task automatic bit_a(input logic b, output logic r);
        a_mosi = b; half(); r = a_miso; a_sck = 1'b1; half(); a_sck = 1'b0;
    endtask

    task automatic bit_b(input logic b, output logic r);
        b_sck = 1'b0; b_mosi = b; half(); r = b_miso; b_sck = 1'b1; half();
    endtask

    task automatic byte_a(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_a(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic word_b(input logic [15:0] tx, input int n, output logic [15:0] rx);
        logic r;
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            bit_b(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic start_a(); a_cs_n = 1'b0; half(); endtask
    task automatic stop_a(); half(); a_cs_n = 1'b1; half(); half(); endtask
    task automatic start_b(); b_cs_n = 1'b0; half(); endtask
    task automatic stop_b(); half(); b_cs_n = 1'b1; half(); half(); endtask

    task automatic test_reset();
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", a_busy); end
        total++; if (a_addr !== 7'h00) begin bad++; $display("FAIL rst_addr got=%h exp=00", a_addr); end
        total++; if (a_do !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", a_do); end
        total++; if (a_dv !== 1'b0 || a_rd !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%b%b exp=00", a_dv, a_rd); end
        total++; if (a_miso !== 1'b0 || b_miso !== 1'b0) begin bad++; $display("FAIL rst_miso got=%b%b exp=00", a_miso, b_miso); end
        total++; if (b_busy !== 1'b0 || b_addr !== 7'h00) begin bad++; $display("FAIL rst_b got=%b/%h exp=0/00", b_busy, b_addr); end
        rstb = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] rx;
        clear_q();
        start_a();
        byte_a(8'h85, rx);
        byte_a(8'hA5, rx);
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL wr_busy_on got=%b exp=1", a_busy); end
        stop_a();
        total++; if (a_dv_addr.size() != 1) begin bad++; $display("FAIL wr_dv_count got=%0d exp=1", a_dv_addr.size()); end
        total++; if (a_dv_addr[0] !== 7'h05) begin bad++; $display("FAIL wr_addr got=%h exp=05", a_dv_addr[0]); end
        total++; if (a_dv_data[0] !== 8'hA5) begin bad++; $display("FAIL wr_data got=%h exp=a5", a_dv_data[0]); end
        total++; if (a_do !== 8'hA5) begin bad++; $display("FAIL wr_data_hold got=%h exp=a5", a_do); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL wr_busy_off got=%b exp=0", a_busy); end
    endtask

    task automatic test_read();
        logic [7:0] rx;
        logic r;
        regs_a[3] = 8'h3C;
        clear_q();
        start_a();
        byte_a(8'h03, rx);
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) begin
                total++; if (a_rd_addr.size() != 1) begin bad++; $display("FAIL rd_count got=%0d exp=1", a_rd_addr.size()); end
                total++; if (a_rd_addr[0] !== 7'h03) begin bad++; $display("FAIL rd_addr got=%h exp=03", a_rd_addr[0]); end
            end
            bit_a(1'b0, r);
            rx[i] = r;
        end
        stop_a();
        total++; if (rx !== 8'h3C) begin bad++; $display("FAIL rd_miso got=%h exp=3c", rx); end
        total++; if (a_miso !== 1'b0) begin bad++; $display("FAIL rd_miso_idle got=%b exp=0", a_miso); end
    endtask

    task automatic test_wrap();
        logic [7:0] rx, rx0, rx1;
        regs_a[7'h7F] = 8'h96;
        regs_a[7'h00] = 8'h5A;
        clear_q();
        start_a();
        byte_a(8'h7F, rx);
        byte_a(8'h00, rx0);
        byte_a(8'h00, rx1);
        stop_a();
        total++; if (a_rd_addr[0] !== 7'h7F) begin bad++; $display("FAIL wrap_rd0 got=%h exp=7f", a_rd_addr[0]); end
        total++; if (a_rd_addr[1] !== (AUTOINC ? 7'h00 : 7'h7F)) begin bad++; $display("FAIL wrap_rd1 got=%h exp=%h", a_rd_addr[1], AUTOINC ? 7'h00 : 7'h7F); end
        total++; if (rx0 !== 8'h96) begin bad++; $display("FAIL wrap_word0 got=%h exp=96", rx0); end
        total++; if (rx1 !== (AUTOINC ? 8'h5A : 8'h96)) begin bad++; $display("FAIL wrap_word1 got=%h exp=%h", rx1, AUTOINC ? 8'h5A : 8'h96); end
    endtask

    task automatic test_mode3();
        logic [15:0] rx;
        clear_q();
        start_b();
        word_b(16'h00FE, 8, rx);
        word_b(16'h1234, 16, rx);
        word_b(16'hABCD, 16, rx);
        stop_b();
        total++; if (b_dv_addr.size() != 2) begin bad++; $display("FAIL m3_dv_count got=%0d exp=2", b_dv_addr.size()); end
        total++; if (b_dv_addr[0] !== 7'h7E || b_dv_data[0] !== 16'h1234) begin bad++; $display("FAIL m3_word0 got=%h/%h exp=7e/1234", b_dv_addr[0], b_dv_data[0]); end
        total++; if (b_dv_addr[1] !== (AUTOINC ? 7'h7F : 7'h7E)) begin bad++; $display("FAIL m3_addr1 got=%h exp=%h", b_dv_addr[1], AUTOINC ? 7'h7F : 7'h7E); end
        total++; if (b_dv_data[1] !== 16'hABCD) begin bad++; $display("FAIL m3_data1 got=%h exp=abcd", b_dv_data[1]); end
        regs_b[7'h10] = 16'hBEEF;
        clear_q();
        start_b();
        word_b(16'h0010, 8, rx);
        word_b(16'h0000, 16, rx);
        stop_b();
        total++; if (b_rd_addr[0] !== 7'h10) begin bad++; $display("FAIL m3_rd_addr got=%h exp=10", b_rd_addr[0]); end
        total++; if (rx !== 16'hBEEF) begin bad++; $display("FAIL m3_rd_miso got=%h exp=beef", rx); end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        logic r;
        clear_q();
        start_a();
        byte_a(8'h81, rx);
        for (int i = 0; i < 5; i++) bit_a(i[0], r);
        stop_a();
        total++; if (a_dv_addr.size() != 0) begin bad++; $display("FAIL abort_no_dv got=%0d exp=0", a_dv_addr.size()); end
        total++; if (a_addr !== 7'h01) begin bad++; $display("FAIL abort_addr got=%h exp=01", a_addr); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", a_busy); end
        start_a();
        byte_a(8'h81, rx);
        byte_a(8'h55, rx);
        stop_a();
        total++; if (a_dv_addr.size() != 1 || a_dv_addr[0] !== 7'h01 || a_dv_data[0] !== 8'h55) begin
            bad++; $display("FAIL abort_next got=%0d/%h/%h exp=1/01/55", a_dv_addr.size(), a_dv_addr[0], a_dv_data[0]);
        end
        start_a();
        for (int i = 0; i < 3; i++) bit_a(1'b1, r);
        stop_a();
        total++; if (a_addr !== (AUTOINC ? 7'h02 : 7'h01)) begin bad++; $display("FAIL partial_cmd_addr got=%h exp=%h", a_addr, AUTOINC ? 7'h02 : 7'h01); end
        total++; if (a_dv_addr.size() != 1) begin bad++; $display("FAIL partial_cmd_dv got=%0d exp=1", a_dv_addr.size()); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        logic r;
        clear_q();
        start_a();
        byte_a(8'hC0, rx);
        byte_a(8'h11, rx);
        for (int i = 0; i < 3; i++) bit_a(1'b1, r);
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (a_busy !== 1'b0 || a_addr !== 7'h00) begin bad++; $display("FAIL midrst_state got=%b/%h exp=0/00", a_busy, a_addr); end
        total++; if (a_do !== 8'h00 || a_dv !== 1'b0) begin bad++; $display("FAIL midrst_out got=%h/%b exp=00/0", a_do, a_dv); end
        rstb = 1'b1;
        for (int i = 0; i < 5; i++) bit_a(1'b1, r);
        byte_a(8'h22, rx);
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL midrst_ignored got=%b exp=0", a_busy); end
        stop_a();
        total++; if (a_dv_addr.size() != 1 || a_dv_addr[0] !== 7'h40 || a_dv_data[0] !== 8'h11) begin
            bad++; $display("FAIL midrst_dv got=%0d/%h/%h exp=1/40/11", a_dv_addr.size(), a_dv_addr[0], a_dv_data[0]);
        end
        start_a();
        byte_a(8'h82, rx);
        byte_a(8'h77, rx);
        stop_a();
        total++; if (a_dv_addr.size() != 2 || a_dv_addr[1] !== 7'h02 || a_dv_data[1] !== 8'h77) begin
            bad++; $display("FAIL midrst_resume got=%0d/%h/%h exp=2/02/77", a_dv_addr.size(), a_dv_addr[1], a_dv_data[1]);
        end
    endtask

    task automatic test_ena();
        logic [7:0] rx;
        logic [7:0] tx;
        logic r;
        tx = 8'hC3;
        clear_q();
        start_a();
        byte_a(8'h84, rx);
        for (int i = 7; i >= 1; i--) bit_a(tx[i], r);
        a_mosi = tx[0];
        half();
        a_sck = 1'b1;
        ena = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (a_dv_addr.size() != 0) begin bad++; $display("FAIL ena_frozen_dv got=%0d exp=0", a_dv_addr.size()); end
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL ena_frozen_busy got=%b exp=1", a_busy); end
        ena = 1'b1;
        half();
        a_sck = 1'b0;
        stop_a();
        total++; if (a_dv_addr.size() != 1 || a_dv_addr[0] !== 7'h04 || a_dv_data[0] !== 8'hC3) begin
            bad++; $display("FAIL ena_resume got=%0d/%h/%h exp=1/04/c3", a_dv_addr.size(), a_dv_addr[0], a_dv_data[0]);
        end
        total++; if (ovl != 0) begin bad++; $display("FAIL strobe_overlap got=%0d exp=0", ovl); end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            regs_a[i] = 8'h00;
            regs_b[i] = 16'h0000;
        end
        ena = 1'b1;
        a_sck = 1'b0; a_cs_n = 1'b1; a_mosi = 1'b0;
        b_sck = 1'b1; b_cs_n = 1'b1; b_mosi = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_mode3();
        test_abort();
        test_reset_mid();
        test_ena();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
